wta_vote_tally: RTL and testbench
=================================

# wta_vote_tally

Downstream consumer of the single-layer winner-take-all output. Samples `winning_neuron` and `output_spike_time` once per time period, accumulates per-neuron win counts over an epoch of `EPOCH_LEN` periods, then scans the counts sequentially for the majority winner. The result is presented on a valid/ready handshake to the classification/readout logic.

## Interface
Parameters:
- `NUM_NEURONS`, 16: neurons in the layer. Index `NUM_NEURONS` is the "no winner" sentinel.
- `LOG_NEURONS`, 4: log2(`NUM_NEURONS`).
- `TIME_PERIOD`, 32: cycles per time period. Must satisfy `TIME_PERIOD > NUM_NEURONS+1`.
- `LOG_TP`, 5: log2(`TIME_PERIOD`).
- `EPOCH_LEN`, 8: periods per epoch, minimum 1.
- `CNT_W`, 8: width of the vote counters. Must satisfy `EPOCH_LEN <= 2^CNT_W-1`.

Ports:
- `clk`, in, 1: clock.
- `rst_l`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: capture enable. When 0, period ends are ignored.
- `time_val`, in, `LOG_TP+1`: free-running period counter driven by the top level.
- `winning_neuron`, in, `LOG_NEURONS+1`: layer winner index.
- `output_spike_time`, in, `LOG_TP+1`: winner's spike time. A value `>= TIME_PERIOD` means no spike.
- `result_valid`, out, 1: result available.
- `result_ready`, in, 1: consumer accepts the result.
- `result_neuron`, out, `LOG_NEURONS+1`: majority winner, or `NUM_NEURONS` if the epoch produced no valid wins.
- `result_votes`, out, `CNT_W`: vote count of `result_neuron`.
- `result_silent`, out, `CNT_W`: number of no-spike periods in the epoch.
- `overrun`, out, 1: sticky. A period or epoch was dropped.

## Operation
- Capture event: a rising edge with `en==1` and `time_val==TIME_PERIOD-1`.
- Valid win: `output_spike_time < TIME_PERIOD` and `winning_neuron < NUM_NEURONS`. On a valid win, `votes[winning_neuron]` increments, saturating at all-ones. Any other capture increments `silent`, also saturating.
- Every capture increments `period_cnt`.
- States:
  - ACCUM: captures are tallied. A capture with `period_cnt==EPOCH_LEN-1` tallies normally, clears `period_cnt`, and moves to SCAN.
  - SCAN: index `i` runs from 0 to `NUM_NEURONS-1`, one neuron per cycle. The best pair (idx, cnt) is updated only when `votes[i] > best_cnt`, so the strictly greater count wins and ties go to the lowest index. After `i==NUM_NEURONS-1`, the block registers `result_*` (index = `NUM_NEURONS` if `best_cnt==0`), clears all `votes` and `silent`, and moves to HOLD. A capture arriving during SCAN is dropped and sets `overrun`.
  - HOLD: `result_valid=1` and the `result_*` outputs are stable. Captures keep tallying into the cleared counters for the next epoch. When `result_valid && result_ready`, the state returns to ACCUM. If an epoch completes while in HOLD, its tally is discarded (counters cleared, `period_cnt=0`), `overrun` is set, and the pending result stays unchanged.
- `overrun` clears only on reset.

## Timing
- Reset values: `result_valid=0`, `result_neuron=NUM_NEURONS`, `result_votes=0`, `result_silent=0`, `overrun=0`. All counters are 0 and the state is ACCUM.
- Reset mid-operation (including SCAN or HOLD) abandons everything immediately.
- `result_valid` rises `NUM_NEURONS+1` edges after the final capture edge of the epoch: 1 edge to enter SCAN, then `NUM_NEURONS` scan edges.
- Handshake:
  - The result is transferred on the edge where `valid && ready`. `result_valid` falls on that same edge.
  - `ready` may be held high permanently, which gives a 1-cycle `valid` pulse.
  - There is no combinational path from `result_ready` to any output.
- A capture and a handshake on the same edge are both honored: the tally is applied and the state goes to ACCUM.
- Epoch completion and a handshake on the same edge: the handshake wins. The completed epoch goes to SCAN with no overrun.

## Structure
- Shared constants go in `internal_defines.vh`: `NUM_NEURONS`, `LOG_NEURONS`, `TIME_PERIOD`, `LOG_TP`, and the sentinel value `NO_WINNER=NUM_NEURONS`.
- State encoding (ACCUM/SCAN/HOLD) lives as localparams in the block.
- One sub-module, `vote_argmax`: the sequential scan datapath. It takes `start`, a count read by index, and `i`, and produces `best_idx`, `best_cnt` and `done`.
- The vote array is a register array of `NUM_NEURONS × CNT_W`, since it must clear in a single cycle.

## Test plan
1. `EPOCH_LEN=8`, neuron 5 wins all 8 periods at spike time 3 -> `result_valid` after 17 edges; result = 5 / 8 votes / 0 silent.
2. Neuron 2 wins 4 periods, neuron 9 wins 4 periods -> tie resolves to 2 with 4 votes.
3. All 8 periods no-spike (`output_spike_time=TIME_PERIOD`) -> result = 16 / 0 votes / 8 silent.
4. `result_ready=0` for 2 full epochs -> first result held unchanged, `overrun=1`. Then raise `ready` -> `valid` drops and the next epoch tallies from zero.
5. Force a capture during SCAN (`time_val` jump) -> that period is not counted and `overrun=1`.
6. Assert `rst_l=0` mid-SCAN -> outputs return to reset values immediately. A fresh epoch then gives a correct result; `en=0` periods are not counted.

Source files
------------

// File: rtl/wta_vote_tally_pkg.sv
// -----------------------------------------------------------------------------
// wta_vote_tally_pkg
// Shared constants for the winner-take-all vote tally slice: default layer
// geometry, time-period geometry and vote counter sizing. The modules use
// these as parameter defaults so a different layer can override them.
// -----------------------------------------------------------------------------
package wta_vote_tally_pkg;

    // Layer geometry: index NUM_NEURONS_DEF is the "no winner" sentinel.
    localparam int NUM_NEURONS_DEF = 16;
    localparam int LOG_NEURONS_DEF = 4;
    localparam int NO_WINNER_DEF   = NUM_NEURONS_DEF;

    // Cycles per time period; a spike time >= TIME_PERIOD_DEF means no spike.
    localparam int TIME_PERIOD_DEF = 32;
    localparam int LOG_TP_DEF      = 5;

    // Epoch length in periods and vote counter width.
    localparam int EPOCH_LEN_DEF   = 8;
    localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/wta_vote_tally_argmax.sv
// -----------------------------------------------------------------------------
// vote_argmax
// Sequential arg-max over the vote array, one neuron per cycle.
//   clk, rst_l   : clock, asynchronous active-low reset
//   start_i      : one-cycle pulse that restarts the scan at index 0
//   cnt_i        : vote count of neuron idx_o (read by the parent)
//   idx_o        : neuron index currently being examined
//   best_idx_o   : best index including the current neuron
//   best_cnt_o   : best count including the current neuron
//   done_o       : high while the last neuron is being examined; best_*_o
//                  then hold the final answer
// Only a strictly greater count replaces the best pair, so ties keep the
// lowest index.
// -----------------------------------------------------------------------------
module vote_argmax
    import wta_vote_tally_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int LOG_NEURONS = LOG_NEURONS_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   start_i,
    input  logic [CNT_W-1:0]       cnt_i,
    output logic [LOG_NEURONS-1:0] idx_o,
    output logic [LOG_NEURONS:0]   best_idx_o,
    output logic [CNT_W-1:0]       best_cnt_o,
    output logic                   done_o
);

    localparam logic [LOG_NEURONS-1:0] IDX_LAST  = LOG_NEURONS'(NUM_NEURONS - 1);
    localparam logic [LOG_NEURONS:0]   NO_WINNER = (LOG_NEURONS + 1)'(NUM_NEURONS);

    logic                   active_q;
    logic [LOG_NEURONS-1:0] idx_q;
    logic [LOG_NEURONS:0]   best_idx_q;
    logic [CNT_W-1:0]       best_cnt_q;
    logic [LOG_NEURONS:0]   best_idx_d;
    logic [CNT_W-1:0]       best_cnt_d;

    // Fold the current neuron into the running best pair.
    always_comb begin
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
        if (cnt_i > best_cnt_q) begin
            best_idx_d = {1'b0, idx_q};
            best_cnt_d = cnt_i;
        end else begin
            best_idx_d = best_idx_q;
            best_cnt_d = best_cnt_q;
        end
    end

    assign idx_o      = idx_q;
    assign best_idx_o = best_idx_d;
    assign best_cnt_o = best_cnt_d;
    assign done_o     = active_q && (idx_q == IDX_LAST);

    // Scan index and running best registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            active_q   <= 1'b0;
            idx_q      <= '0;
            best_idx_q <= NO_WINNER;
            best_cnt_q <= '0;
        end else if (start_i) begin
            active_q   <= 1'b1;
            idx_q      <= '0;
            best_idx_q <= NO_WINNER;
            best_cnt_q <= '0;
        end else if (active_q) begin
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
            if (idx_q == IDX_LAST) begin
                active_q <= 1'b0;
            end else begin
                idx_q <= idx_q + LOG_NEURONS'(1);
            end
        end
    end

endmodule

// File: rtl/wta_vote_tally.sv
// -----------------------------------------------------------------------------
// wta_vote_tally
// Tallies the winner-take-all layer output once per time period over an
// epoch, then scans the tallies for the majority winner and offers it on a
// valid/ready handshake.
//   clk, rst_l         : clock, asynchronous active-low reset
//   en                 : capture enable (period ends ignored when low)
//   time_val           : free-running period counter
//   winning_neuron     : layer winner index (NUM_NEURONS = no winner)
//   output_spike_time  : winner spike time (>= TIME_PERIOD = no spike)
//   result_valid/ready : result handshake
//   result_neuron      : majority winner, NUM_NEURONS if no valid wins
//   result_votes       : votes of result_neuron
//   result_silent      : no-spike periods in the epoch
//   overrun            : sticky, a period or an epoch was dropped
// -----------------------------------------------------------------------------
module wta_vote_tally
    import wta_vote_tally_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int LOG_NEURONS = LOG_NEURONS_DEF,
    parameter int TIME_PERIOD = TIME_PERIOD_DEF,
    parameter int LOG_TP      = LOG_TP_DEF,
    parameter int EPOCH_LEN   = EPOCH_LEN_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 en,
    input  logic [LOG_TP:0]      time_val,
    input  logic [LOG_NEURONS:0] winning_neuron,
    input  logic [LOG_TP:0]      output_spike_time,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [LOG_NEURONS:0] result_neuron,
    output logic [CNT_W-1:0]     result_votes,
    output logic [CNT_W-1:0]     result_silent,
    output logic                 overrun
);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [LOG_TP:0]      TP_LAST    = (LOG_TP + 1)'(TIME_PERIOD - 1);
    localparam logic [LOG_TP:0]      TP_NONE    = (LOG_TP + 1)'(TIME_PERIOD);
    localparam logic [LOG_NEURONS:0] NO_WINNER  = (LOG_NEURONS + 1)'(NUM_NEURONS);
    localparam logic [CNT_W-1:0]     EPOCH_LAST = CNT_W'(EPOCH_LEN - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX    = {CNT_W{1'b1}};

    // Saturating increment for vote/silent counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       votes_q [NUM_NEURONS];
    logic [CNT_W-1:0]       silent_q;
    logic [CNT_W-1:0]       period_cnt_q;
    logic                   scan_start_q, scan_start_d;
    logic                   result_valid_q;
    logic [LOG_NEURONS:0]   result_neuron_q;
    logic [CNT_W-1:0]       result_votes_q;
    logic [CNT_W-1:0]       result_silent_q;
    logic                   overrun_q;

    logic                   capture_s, win_s, epoch_end_s, handshake_s;
    logic                   tally_s, drop_s, discard_s, load_s;
    logic [LOG_NEURONS-1:0] scan_idx_s;
    logic [LOG_NEURONS:0]   best_idx_s;
    logic [CNT_W-1:0]       best_cnt_s;
    logic                   scan_done_s;

    assign capture_s   = en && (time_val == TP_LAST);
    assign win_s       = (output_spike_time < TP_NONE) && (winning_neuron < NO_WINNER);
    assign epoch_end_s = capture_s && (period_cnt_q == EPOCH_LAST);
    assign handshake_s = result_valid_q && result_ready;

    vote_argmax #(
        .NUM_NEURONS (NUM_NEURONS),
        .LOG_NEURONS (LOG_NEURONS),
        .CNT_W       (CNT_W)
    ) u_argmax (
        .clk        (clk),
        .rst_l      (rst_l),
        .start_i    (scan_start_q),
        .cnt_i      (votes_q[scan_idx_s]),
        .idx_o      (scan_idx_s),
        .best_idx_o (best_idx_s),
        .best_cnt_o (best_cnt_s),
        .done_o     (scan_done_s)
    );

    // FSM state register plus the registered handshake/scan-start flags.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q        <= ST_ACCUM;
            scan_start_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            scan_start_q   <= scan_start_d;
            result_valid_q <= (state_d == ST_HOLD);
        end
    end

    // Next-state logic; a handshake outranks an epoch completing in HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: begin
                if (epoch_end_s) state_d = ST_SCAN;
                else             state_d = ST_ACCUM;
            end
            ST_SCAN: begin
                if (scan_done_s) state_d = ST_HOLD;
                else             state_d = ST_SCAN;
            end
            ST_HOLD: begin
                if (handshake_s) state_d = epoch_end_s ? ST_SCAN : ST_ACCUM;
                else             state_d = ST_HOLD;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // Per-state datapath controls.
    always_comb begin
        tally_s   = 1'b0;
        drop_s    = 1'b0;
        discard_s = 1'b0;
        load_s    = 1'b0;
        case (state_q)
            ST_ACCUM: tally_s = capture_s;
            ST_SCAN: begin
                drop_s = capture_s;
                load_s = scan_done_s;
            end
            ST_HOLD: begin
                // An epoch finishing with the result still pending is lost.
                if (handshake_s || !epoch_end_s) tally_s   = capture_s;
                else                             discard_s = 1'b1;
            end
            default: tally_s = 1'b0;
        endcase
        // The scan begins one edge after the state first becomes SCAN.
        scan_start_d = (state_d == ST_SCAN) && (state_q != ST_SCAN);
    end

    // Vote, silent and period counters.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int n = 0; n < NUM_NEURONS; n++) votes_q[n] <= '0;
            silent_q     <= '0;
            period_cnt_q <= '0;
        end else begin
            if (load_s || discard_s) begin
                for (int n = 0; n < NUM_NEURONS; n++) votes_q[n] <= '0;
                silent_q <= '0;
            end else if (tally_s) begin
                if (win_s) begin
                    votes_q[winning_neuron[LOG_NEURONS-1:0]] <=
                        sat_inc(votes_q[winning_neuron[LOG_NEURONS-1:0]]);
                end else begin
                    silent_q <= sat_inc(silent_q);
                end
            end
            if (tally_s) begin
                period_cnt_q <= epoch_end_s ? '0 : period_cnt_q + CNT_W'(1);
            end else if (discard_s) begin
                period_cnt_q <= '0;
            end
        end
    end

    // Result registers and the sticky overrun flag.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            result_neuron_q <= NO_WINNER;
            result_votes_q  <= '0;
            result_silent_q <= '0;
            overrun_q       <= 1'b0;
        end else begin
            if (load_s) begin
                result_neuron_q <= (best_cnt_s == '0) ? NO_WINNER : best_idx_s;
                result_votes_q  <= best_cnt_s;
                result_silent_q <= silent_q;
            end
            if (drop_s || discard_s) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign result_valid  = result_valid_q;
    assign result_neuron = result_neuron_q;
    assign result_votes  = result_votes_q;
    assign result_silent = result_silent_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_wta_vote_tally.sv
// -----------------------------------------------------------------------------
// tb_wta_vote_tally
// Directed bench for wta_vote_tally. Stimulus queues expected results; a
// separate monitor compares them when the DUT transfers a result, and also
// drains a queue of one-off observations posted by the stimulus.
// -----------------------------------------------------------------------------
module tb_wta_vote_tally;

    logic       clk;
    logic       rst_l;
    logic       en;
    logic [5:0] time_val;
    logic [4:0] winning_neuron;
    logic [5:0] output_spike_time;
    logic       result_valid;
    logic       result_ready;
    logic [4:0] result_neuron;
    logic [7:0] result_votes;
    logic [7:0] result_silent;
    logic       overrun;

    typedef struct packed {
        logic [4:0] n;
        logic [7:0] v;
        logic [7:0] s;
    } exp_t;

    exp_t  sb_q[$];
    string dn_q[$];
    int    da_q[$];
    int    de_q[$];
    int    checks;
    int    errors;
    int    jump_cnt;

    wta_vote_tally dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .en                (en),
        .time_val          (time_val),
        .winning_neuron    (winning_neuron),
        .output_spike_time (output_spike_time),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .result_neuron     (result_neuron),
        .result_votes      (result_votes),
        .result_silent     (result_silent),
        .overrun           (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running period counter; a jump request forces the last count.
    initial begin
        int seen;
        seen     = 0;
        time_val = 6'd0;
        forever begin
            @(negedge clk);
            if (jump_cnt != seen) begin
                seen     = jump_cnt;
                time_val = 6'd31;
            end else if (time_val == 6'd31) begin
                time_val = 6'd0;
            end else begin
                time_val = time_val + 6'd1;
            end
        end
    end

    // Monitor: all comparisons happen here.
    initial begin
        exp_t  e;
        string nm;
        int    a;
        int    x;
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk);
            while (dn_q.size() > 0) begin
                nm = dn_q.pop_front();
                a  = da_q.pop_front();
                x  = de_q.pop_front();
                checks++;
                if (a != x) begin
                    errors++;
                    $display("FAIL %s: got %0d expected %0d", nm, a, x);
                end
            end
            if (rst_l && result_valid && result_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got neuron %0d votes %0d, nothing expected",
                             result_neuron, result_votes);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if (result_neuron != e.n) begin
                        errors++;
                        $display("FAIL result_neuron: got %0d expected %0d", result_neuron, e.n);
                    end
                    checks++;
                    if (result_votes != e.v) begin
                        errors++;
                        $display("FAIL result_votes: got %0d expected %0d", result_votes, e.v);
                    end
                    checks++;
                    if (result_silent != e.s) begin
                        errors++;
                        $display("FAIL result_silent: got %0d expected %0d", result_silent, e.s);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic post(input string name, input int act, input int exp);
        dn_q.push_back(name);
        da_q.push_back(act);
        de_q.push_back(exp);
    endtask

    task automatic expect_result(input logic [4:0] n, input logic [7:0] v, input logic [7:0] s);
        exp_t e;
        e.n = n;
        e.v = v;
        e.s = s;
        sb_q.push_back(e);
    endtask

    // Present one period's layer output and wait for its capture edge.
    task automatic period(input logic [4:0] wn, input logic [5:0] st);
        bit got;
        got               = 1'b0;
        winning_neuron    = wn;
        output_spike_time = st;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            if (time_val == 6'd31) got = 1'b1;
        end
        if (!got) post("capture_wait", 0, 1);
        #1;
    endtask

    task automatic wait_valid();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge clk);
            #1;
            if (result_valid) got = 1'b1;
        end
        if (!got) post("valid_wait", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        post({tag, "_valid"},   result_valid,  0);
        post({tag, "_neuron"},  result_neuron, 16);
        post({tag, "_votes"},   result_votes,  0);
        post({tag, "_silent"},  result_silent, 0);
        post({tag, "_overrun"}, overrun,       0);
    endtask

    initial begin
        int lat;
        bit got;
        jump_cnt          = 0;
        rst_l             = 1'b0;
        en                = 1'b0;
        result_ready      = 1'b1;
        winning_neuron    = 5'd16;
        output_spike_time = 6'd32;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_l = 1'b1;

        // Neuron 5 wins every period; measure result latency.
        en = 1'b1;
        expect_result(5'd5, 8'd8, 8'd0);
        repeat (8) period(5'd5, 6'd3);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                got = 1'b1;
                lat = k;
            end
        end
        post("valid_latency", lat, 17);

        // Four-four tie between 2 and 9 resolves to the lower index.
        expect_result(5'd2, 8'd4, 8'd0);
        repeat (4) period(5'd2, 6'd10);
        repeat (4) period(5'd9, 6'd10);
        wait_valid();

        // All silent periods give the sentinel.
        expect_result(5'd16, 8'd0, 8'd8);
        repeat (8) period(5'd0, 6'd32);
        wait_valid();
        post("overrun_clean", overrun, 0);

        // Capture forced during SCAN on neuron 10 must not break the 6/10 tie.
        expect_result(5'd6, 8'd4, 8'd0);
        repeat (4) period(5'd6, 6'd5);
        repeat (4) period(5'd10, 6'd5);
        winning_neuron    = 5'd10;
        output_spike_time = 6'd2;
        jump_cnt          = jump_cnt + 1;
        wait_valid();
        post("overrun_scan_drop", overrun, 1);
        // The dropped period must not shorten the following epoch.
        expect_result(5'd8, 8'd8, 8'd0);
        repeat (8) period(5'd8, 6'd1);
        wait_valid();

        // Reset in the middle of a scan abandons it.
        repeat (8) period(5'd11, 6'd4);
        repeat (5) @(posedge clk);
        #3;
        rst_l = 1'b0;
        #1;
        check_reset_outputs("mid_scan_reset");
        en = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        repeat (3) period(5'd1, 6'd1);
        en = 1'b1;
        expect_result(5'd12, 8'd5, 8'd3);
        repeat (5) period(5'd12, 6'd4);
        repeat (3) period(5'd0, 6'd40);
        wait_valid();

        // Consumer stalls across a second epoch.
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        expect_result(5'd7, 8'd8, 8'd0);
        repeat (8) period(5'd7, 6'd2);
        wait_valid();
        repeat (8) period(5'd3, 6'd2);
        post("hold_valid",   result_valid,  1);
        post("hold_neuron",  result_neuron, 7);
        post("hold_votes",   result_votes,  8);
        post("hold_silent",  result_silent, 0);
        post("hold_overrun", overrun,       1);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        post("valid_drop", result_valid, 0);
        expect_result(5'd4, 8'd3, 8'd5);
        period(5'd4, 6'd0);
        period(5'd4, 6'd31);
        period(5'd4, 6'd7);
        repeat (3) period(5'd4, 6'd32);
        repeat (2) period(5'd16, 6'd5);
        wait_valid();

        repeat (3) @(negedge clk);
        post("scoreboard_empty", sb_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
